// File: rtl/roce_pkg.sv
// Shared RoCE RC definitions: PSN type, scheduler states, PSN arithmetic and
// the RC opcodes used by the QP state, TX and retransmit blocks.
package roce_pkg;

  localparam int PSN_WIDTH = 24;

  typedef logic [PSN_WIDTH-1:0] psn_t;

  typedef enum logic [1:0] {
    STATE_IDLE    = 2'd0,
    STATE_RUN     = 2'd1,
    STATE_RETRANS = 2'd2,
    STATE_ERROR   = 2'd3
  } state_t;

  localparam logic [7:0] RC_SEND_FIRST         = 8'h00;
  localparam logic [7:0] RC_SEND_MIDDLE        = 8'h01;
  localparam logic [7:0] RC_SEND_LAST          = 8'h02;
  localparam logic [7:0] RC_SEND_ONLY          = 8'h04;
  localparam logic [7:0] RC_RDMA_WRITE_FIRST   = 8'h06;
  localparam logic [7:0] RC_RDMA_WRITE_MIDDLE  = 8'h07;
  localparam logic [7:0] RC_RDMA_WRITE_LAST    = 8'h08;
  localparam logic [7:0] RC_RDMA_WRITE_ONLY    = 8'h0A;
  localparam logic [7:0] RC_ACKNOWLEDGE        = 8'h11;

  // Distance from b forward to a on the 24-bit PSN ring.
  function automatic psn_t psn_diff(input psn_t a, input psn_t b);
    return a - b;
  endfunction

endpackage

// File: rtl/roce_retrans_scheduler_if.sv
// TX-generator facing handshake of the retransmit scheduler: new-PSN stream
// in, credit gate and retransmit-from-PSN request out.
interface roce_retrans_scheduler_if;
  import roce_pkg::*;

  logic s_tx_psn_valid;
  psn_t s_tx_psn;
  logic tx_allow;
  logic m_retrans_valid;
  logic m_retrans_ready;
  psn_t m_retrans_psn;

  modport master (
    input  s_tx_psn_valid, s_tx_psn, m_retrans_ready,
    output tx_allow, m_retrans_valid, m_retrans_psn
  );

  modport slave (
    output s_tx_psn_valid, s_tx_psn, m_retrans_ready,
    input  tx_allow, m_retrans_valid, m_retrans_psn
  );

endinterface

// File: rtl/roce_ack_timer.sv
// ACK timeout counter: clear has priority over enable; it saturates at LIMIT
// and holds expire_o high until cleared.
module roce_ack_timer #(
  parameter int unsigned LIMIT = 65536
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  logic [31:0] cnt_q;

  assign expire_o = (cnt_q == LIMIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (en_i && !expire_o) begin
      cnt_q <= cnt_q + 32'd1;
    end
  end

endmodule

// File: rtl/roce_retrans_scheduler.sv
// Go-back-N transmit sequencer for one RC QP: in-flight window, credit gate,
// ACK timeout, NAK/timeout retransmit requests and retry-budget error.
module roce_retrans_scheduler
  import roce_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES  = 65536,
  parameter int unsigned MAX_RETRIES     = 7,
  parameter int unsigned MAX_OUTSTANDING = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       qp_open,
  input  psn_t       qp_start_psn,
  input  psn_t       last_acked_psn,
  input  psn_t       last_nacked_psn,
  input  logic       stop_transfer,
  roce_retrans_scheduler_if.master tx_if,
  output psn_t       outstanding,
  output logic [3:0] retry_count,
  output logic       qp_error
);

  state_t     state_q, state_d;
  psn_t       base_q, base_d;
  psn_t       next_q, next_d;
  logic [3:0] retry_q, retry_d;
  logic       err_q, err_d;
  logic       rv_q, rv_d;
  psn_t       rpsn_q, rpsn_d;
  psn_t       prev_ack_q;
  logic       prev_stop_q;

  logic       tmr_clr, tmr_en, tmr_expire;
  logic       window_open, ack_ok, nak_rise, timeout, trig, nak_in_win;
  psn_t       ack_dist, base_eff, next_eff, trig_psn;
  logic [3:0] retry_base;
  logic [4:0] retry_new;

  roce_ack_timer #(.LIMIT(TIMEOUT_CYCLES)) u_ack_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_i    (tmr_clr),
    .en_i     (tmr_en),
    .expire_o (tmr_expire)
  );

  assign outstanding           = psn_diff(next_q, base_q);
  assign tx_if.tx_allow        = (state_q == STATE_RUN) && (32'(outstanding) < MAX_OUTSTANDING);
  assign tx_if.m_retrans_valid = rv_q;
  assign tx_if.m_retrans_psn   = rpsn_q;
  assign retry_count           = retry_q;
  assign qp_error              = err_q;

  // ACK is applied first so a simultaneous NAK is judged against the new base.
  assign window_open = (state_q == STATE_RUN) || (state_q == STATE_RETRANS);
  assign ack_dist    = psn_diff(last_acked_psn + 24'd1, base_q);
  assign ack_ok      = window_open && (last_acked_psn != prev_ack_q) &&
                       (ack_dist != '0) && (ack_dist <= outstanding);
  assign base_eff    = ack_ok ? (last_acked_psn + 24'd1) : base_q;
  assign next_eff    = ((state_q == STATE_RUN) && tx_if.s_tx_psn_valid) ?
                       (tx_if.s_tx_psn + 24'd1) : next_q;

  assign nak_rise    = stop_transfer && !prev_stop_q;
  assign timeout     = tmr_expire && !ack_ok;
  assign trig        = (state_q == STATE_RUN) && (nak_rise || timeout);
  assign nak_in_win  = psn_diff(last_nacked_psn, base_eff) < psn_diff(next_eff, base_eff);
  assign trig_psn    = (nak_rise && nak_in_win) ? last_nacked_psn : base_eff;
  assign retry_base  = ack_ok ? 4'd0 : retry_q;
  assign retry_new   = {1'b0, retry_base} + 5'd1;
  assign tmr_en      = (state_q == STATE_RUN) && (outstanding != '0);

  always_comb begin
    state_d = state_q;
    base_d  = base_eff;
    next_d  = next_eff;
    retry_d = retry_base;
    err_d   = err_q;
    rv_d    = rv_q;
    rpsn_d  = rpsn_q;
    tmr_clr = ack_ok || (outstanding == '0);

    case (state_q)
      STATE_RUN: begin
        if (trig) begin
          retry_d = retry_new[4] ? 4'hF : retry_new[3:0];
          tmr_clr = 1'b1;
          if (32'(retry_new) > MAX_RETRIES) begin
            state_d = STATE_ERROR;
            err_d   = 1'b1;
          end else begin
            state_d = STATE_RETRANS;
            rv_d    = 1'b1;
            rpsn_d  = trig_psn;
          end
        end
      end
      STATE_RETRANS: begin
        if (rv_q && tx_if.m_retrans_ready) begin
          next_d  = rpsn_q;
          rv_d    = 1'b0;
          state_d = STATE_RUN;
        end
      end
      default: ;
    endcase

    // Session (re)open overrides everything, including a pending request.
    if (qp_open) begin
      state_d = STATE_RUN;
      base_d  = qp_start_psn;
      next_d  = qp_start_psn;
      retry_d = '0;
      err_d   = 1'b0;
      rv_d    = 1'b0;
      tmr_clr = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= STATE_IDLE;
      base_q      <= '0;
      next_q      <= '0;
      retry_q     <= '0;
      err_q       <= 1'b0;
      rv_q        <= 1'b0;
      rpsn_q      <= '0;
      prev_ack_q  <= '0;
      prev_stop_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      next_q      <= next_d;
      retry_q     <= retry_d;
      err_q       <= err_d;
      rv_q        <= rv_d;
      rpsn_q      <= rpsn_d;
      prev_ack_q  <= last_acked_psn;
      prev_stop_q <= stop_transfer;
    end
  end

endmodule

// File: tb/tb_roce_retrans_scheduler.sv
// Directed bench for roce_retrans_scheduler; retransmit handshakes are checked
// against a queue of expected requests by a separate monitor.
module tb_roce_retrans_scheduler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        qp_open;
  logic [23:0] qp_start_psn;
  logic [23:0] last_acked_psn;
  logic [23:0] last_nacked_psn;
  logic        stop_transfer;
  logic [23:0] outstanding;
  logic [3:0]  retry_count;
  logic        qp_error;

  roce_retrans_scheduler_if tx_if ();

  roce_retrans_scheduler #(
    .TIMEOUT_CYCLES  (100),
    .MAX_RETRIES     (7),
    .MAX_OUTSTANDING (4)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .qp_open         (qp_open),
    .qp_start_psn    (qp_start_psn),
    .last_acked_psn  (last_acked_psn),
    .last_nacked_psn (last_nacked_psn),
    .stop_transfer   (stop_transfer),
    .tx_if           (tx_if),
    .outstanding     (outstanding),
    .retry_count     (retry_count),
    .qp_error        (qp_error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [23:0] psn;
    logic [3:0]  retry;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic emit(input logic [23:0] p);
    tx_if.s_tx_psn_valid = 1'b1;
    tx_if.s_tx_psn       = p;
    tick();
    tx_if.s_tx_psn_valid = 1'b0;
  endtask

  task automatic open_qp(input logic [23:0] p);
    qp_open      = 1'b1;
    qp_start_psn = p;
    tick();
    qp_open      = 1'b0;
  endtask

  task automatic handshake();
    tx_if.m_retrans_ready = 1'b1;
    tick();
    tx_if.m_retrans_ready = 1'b0;
  endtask

  // Ticks until a retransmit request or the error flag appears, bounded.
  task automatic wait_event(output int n, input int maxn);
    n = 0;
    do begin
      tick();
      n++;
    end while (!(tx_if.m_retrans_valid || qp_error) && n < maxn);
  endtask

  always @(negedge clk) begin
    if (rst_n && tx_if.m_retrans_valid && tx_if.m_retrans_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL retrans_unexpected: got psn 0x%0h with no request expected", tx_if.m_retrans_psn);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("retrans_psn", 32'(tx_if.m_retrans_psn), 32'(e.psn));
        check("retrans_retry", 32'(retry_count), 32'(e.retry));
      end
    end
  end

  initial begin
    int n;
    rst_n                 = 1'b0;
    qp_open               = 1'b0;
    qp_start_psn          = '0;
    last_acked_psn        = '0;
    last_nacked_psn       = '0;
    stop_transfer         = 1'b0;
    tx_if.s_tx_psn_valid  = 1'b0;
    tx_if.s_tx_psn        = '0;
    tx_if.m_retrans_ready = 1'b0;
    tick(2);
    check("rst_tx_allow", 32'(tx_if.tx_allow), 0);
    check("rst_valid", 32'(tx_if.m_retrans_valid), 0);
    check("rst_outstanding", 32'(outstanding), 0);
    check("rst_retry", 32'(retry_count), 0);
    check("rst_error", 32'(qp_error), 0);
    rst_n = 1'b1;
    tick();
    check("idle_tx_allow", 32'(tx_if.tx_allow), 0);

    // Credit window
    open_qp(24'h000010);
    check("open_tx_allow", 32'(tx_if.tx_allow), 1);
    for (int i = 0; i < 4; i++) begin
      emit(24'h000010 + 24'(i));
      check("credit_outstanding", 32'(outstanding), 32'(i + 1));
      check("credit_tx_allow", 32'(tx_if.tx_allow), (i < 3) ? 1 : 0);
    end
    last_acked_psn = 24'h000011;
    tick();
    check("ack_outstanding", 32'(outstanding), 2);
    check("ack_tx_allow", 32'(tx_if.tx_allow), 1);

    // NAK inside the window
    open_qp(24'h000020);
    for (int i = 0; i < 8; i++) emit(24'h000020 + 24'(i));
    check("nak_pre_outstanding", 32'(outstanding), 8);
    last_nacked_psn = 24'h000023;
    stop_transfer   = 1'b1;
    exp_q.push_back('{psn: 24'h000023, retry: 4'd1});
    tick();
    check("nak_valid", 32'(tx_if.m_retrans_valid), 1);
    check("nak_psn", 32'(tx_if.m_retrans_psn), 32'h23);
    check("nak_retry", 32'(retry_count), 1);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("nak_hold_valid", 32'(tx_if.m_retrans_valid), 1);
      check("nak_hold_psn", 32'(tx_if.m_retrans_psn), 32'h23);
    end
    handshake();
    stop_transfer = 1'b0;
    check("nak_done_valid", 32'(tx_if.m_retrans_valid), 0);
    check("nak_next_psn", 32'(outstanding), 3);

    // Timeouts until the retry budget runs out
    open_qp(24'h000030);
    for (int r = 1; r <= 8; r++) begin
      if (r <= 7) exp_q.push_back('{psn: 24'h000030, retry: 4'(r)});
      emit(24'h000030);
      emit(24'h000031);
      wait_event(n, 300);
      check("timeout_latency", 32'(n + 1), 101);
      check("timeout_retry", 32'(retry_count), 32'(r));
      if (r <= 7) begin
        check("timeout_valid", 32'(tx_if.m_retrans_valid), 1);
        handshake();
      end else begin
        check("err_flag", 32'(qp_error), 1);
        check("err_tx_allow", 32'(tx_if.tx_allow), 0);
        check("err_valid", 32'(tx_if.m_retrans_valid), 0);
      end
    end
    open_qp(24'h000040);
    check("reopen_error", 32'(qp_error), 0);
    check("reopen_tx_allow", 32'(tx_if.tx_allow), 1);
    check("reopen_retry", 32'(retry_count), 0);

    // ACK progress in the exact expiry cycle
    emit(24'h000040);
    emit(24'h000041);
    tick(99);
    last_acked_psn = 24'h000040;
    tick();
    check("race_ack_valid", 32'(tx_if.m_retrans_valid), 0);
    check("race_ack_outstanding", 32'(outstanding), 1);
    exp_q.push_back('{psn: 24'h000041, retry: 4'd1});
    wait_event(n, 300);
    check("race_ack_restart", 32'(n), 101);
    handshake();

    // NAK together with timeout
    emit(24'h000041);
    emit(24'h000042);
    emit(24'h000043);
    tick(98);
    last_nacked_psn = 24'h000042;
    stop_transfer   = 1'b1;
    exp_q.push_back('{psn: 24'h000042, retry: 4'd2});
    tick();
    check("race_nak_valid", 32'(tx_if.m_retrans_valid), 1);
    check("race_nak_psn", 32'(tx_if.m_retrans_psn), 32'h42);
    handshake();
    stop_transfer = 1'b0;
    tick(3);
    check("race_nak_single", 32'(tx_if.m_retrans_valid), 0);
    check("race_nak_outstanding", 32'(outstanding), 1);

    // Window spanning the PSN wrap
    open_qp(24'hFFFFFE);
    emit(24'hFFFFFE);
    emit(24'hFFFFFF);
    emit(24'h000000);
    emit(24'h000001);
    check("wrap_outstanding", 32'(outstanding), 4);
    last_acked_psn = 24'h000000;
    tick();
    check("wrap_ack", 32'(outstanding), 1);
    last_acked_psn = 24'hFFFFF0;
    tick();
    check("wrap_stale", 32'(outstanding), 1);
    check("wrap_tx_allow", 32'(tx_if.tx_allow), 1);

    // Asynchronous reset while a request is pending
    last_nacked_psn = 24'h000001;
    stop_transfer   = 1'b1;
    tick();
    check("rtr_valid", 32'(tx_if.m_retrans_valid), 1);
    #1 rst_n = 1'b0;
    #1;
    check("arst_valid", 32'(tx_if.m_retrans_valid), 0);
    check("arst_psn", 32'(tx_if.m_retrans_psn), 0);
    check("arst_tx_allow", 32'(tx_if.tx_allow), 0);
    check("arst_outstanding", 32'(outstanding), 0);
    check("arst_retry", 32'(retry_count), 0);
    check("arst_error", 32'(qp_error), 0);
    tick();
    rst_n = 1'b1;
    tick(2);
    check("post_rst_tx_allow", 32'(tx_if.tx_allow), 0);
    check("post_rst_valid", 32'(tx_if.m_retrans_valid), 0);
    stop_transfer = 1'b0;
    open_qp(24'h000050);
    check("post_rst_open", 32'(tx_if.tx_allow), 1);

    check("scoreboard_drained", 32'(exp_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
